// File: rtl/turn_scheduler.sv
// Turn sequencer for the chicken race: owns the active pointer, board positions and tail counts,
// issues one compare per card pick, holds the reveal, then advances or passes the turn.
module turn_scheduler_slot #(
   parameter int SLOT  = 0,
   parameter int PW    = 2,
   parameter int POS_W = 5
) (
   input  logic [2:0]       n,
   input  logic [PW-1:0]    active,
   input  logic [POS_W-1:0] pos,
   input  logic [POS_W-1:0] new_pos,
   output logic             hit
);
   // A seated opponent standing on the tile the active chicken just reached.
   assign hit = (3'(SLOT) < n) && (PW'(SLOT) != active) && (pos == new_pos);
endmodule

module turn_scheduler #(
   parameter int MAX_PLAYERS   = 4,
   parameter int TRACK_LEN     = 24,
   parameter int REVEAL_CYCLES = 50000000,
   localparam int PW    = (MAX_PLAYERS > 1) ? $clog2(MAX_PLAYERS) : 1,
   localparam int POS_W = $clog2(TRACK_LEN)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic [2:0]                   num_players,
   input  logic                         pick_valid,
   input  logic [3:0]                   pick_idx,
   output logic                         pick_ready,
   output logic                         cmp_req,
   output logic [3:0]                   cmp_idx,
   input  logic                         cmp_valid,
   input  logic                         cmp_match,
   output logic                         reveal_en,
   output logic [PW-1:0]                active,
   output logic [MAX_PLAYERS*POS_W-1:0] pos_bus,
   output logic [MAX_PLAYERS*3-1:0]     tails_bus,
   output logic                         cfg_err,
   output logic                         winner_valid,
   output logic [PW-1:0]                winner
);
   localparam int         CW   = $clog2(REVEAL_CYCLES + 1);
   localparam logic [2:0] MAXP = 3'(MAX_PLAYERS);

   typedef enum logic [2:0] {S_IDLE, S_WAIT_PICK, S_COMPARE, S_REVEAL, S_RESOLVE, S_DONE} state_t;
   state_t state, state_n;

   logic [2:0]                        n_r;
   logic [MAX_PLAYERS-1:0][POS_W-1:0] pos_r;
   logic [MAX_PLAYERS-1:0][2:0]       tails_r;
   logic [CW-1:0]                     cnt;
   logic                              match_r;
   logic [POS_W-1:0]                  new_pos;
   logic [MAX_PLAYERS-1:0]            hit;
   logic [2:0]                        stolen, new_tails;
   logic                              cfg_bad, win;

   assign pos_bus   = pos_r;
   assign tails_bus = tails_r;
   assign cfg_bad   = (num_players < 3'd2) || (num_players > MAXP);
   assign new_pos   = (pos_r[active] == POS_W'(TRACK_LEN - 1)) ? '0 : pos_r[active] + POS_W'(1);

   for (genvar g = 0; g < MAX_PLAYERS; g++) begin : g_slot
      turn_scheduler_slot #(.SLOT(g), .PW(PW), .POS_W(POS_W)) u_slot (
         .n(n_r), .active(active), .pos(pos_r[g]), .new_pos(new_pos), .hit(hit[g])
      );
   end

   always_comb begin
      stolen = '0;
      for (int j = 0; j < MAX_PLAYERS; j++)
         if (hit[j]) stolen = stolen + tails_r[j];
      new_tails = tails_r[active] + stolen;
      win       = (new_tails == n_r);
   end

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n    = state;
      pick_ready = 1'b0;
      reveal_en  = 1'b0;
      case (state)
         S_IDLE, S_DONE: if (start && !cfg_bad) state_n = S_WAIT_PICK;
         S_WAIT_PICK: begin
            pick_ready = 1'b1;
            if (pick_valid) state_n = S_COMPARE;
         end
         S_COMPARE: if (cmp_valid) state_n = S_REVEAL;
         S_REVEAL: begin
            reveal_en = 1'b1;
            if (cnt == '0) state_n = S_RESOLVE;
         end
         S_RESOLVE: state_n = (match_r && win) ? S_DONE : S_WAIT_PICK;
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         n_r          <= '0;
         pos_r        <= '0;
         tails_r      <= '0;
         cnt          <= '0;
         match_r      <= 1'b0;
         active       <= '0;
         cmp_req      <= 1'b0;
         cmp_idx      <= '0;
         cfg_err      <= 1'b0;
         winner_valid <= 1'b0;
         winner       <= '0;
      end else begin
         cfg_err <= 1'b0;
         cmp_req <= 1'b0;
         case (state)
            S_IDLE, S_DONE: if (start) begin
               if (cfg_bad) cfg_err <= 1'b1;
               else begin
                  n_r          <= num_players;
                  active       <= '0;
                  winner_valid <= 1'b0;
                  for (int i = 0; i < MAX_PLAYERS; i++) begin
                     pos_r[i]   <= (3'(i) < num_players) ? POS_W'(i * (TRACK_LEN / MAX_PLAYERS)) : '0;
                     tails_r[i] <= (3'(i) < num_players) ? 3'd1 : 3'd0;
                  end
               end
            end
            S_WAIT_PICK: if (pick_valid) begin
               cmp_idx <= pick_idx;
               cmp_req <= 1'b1;
            end
            S_COMPARE: if (cmp_valid) begin
               match_r <= cmp_match;
               cnt     <= CW'(REVEAL_CYCLES - 1);
            end
            S_REVEAL: if (cnt != '0) cnt <= cnt - CW'(1);
            S_RESOLVE: begin
               if (!match_r) begin
                  active <= (3'(active) + 3'd1 == n_r) ? '0 : active + PW'(1);
               end else begin
                  pos_r[active] <= new_pos;
                  // Active slot is never a hit, so its write below does not collide.
                  for (int j = 0; j < MAX_PLAYERS; j++)
                     if (hit[j]) tails_r[j] <= 3'd0;
                  tails_r[active] <= new_tails;
                  if (win) begin
                     winner       <= active;
                     winner_valid <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_turn_scheduler.sv
// Directed bench for turn_scheduler with a short reveal window; expected values are hand-computed.
module tb_turn_scheduler;
   localparam int RC = 3;

   logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
   logic [2:0]  num_players = '0;
   logic        pick_valid = 1'b0, cmp_valid = 1'b0, cmp_match = 1'b0;
   logic [3:0]  pick_idx = '0;
   logic        pick_ready, cmp_req, reveal_en, cfg_err, winner_valid;
   logic [3:0]  cmp_idx;
   logic [1:0]  active, winner;
   logic [19:0] pos_bus;
   logic [11:0] tails_bus;
   int total = 0, bad = 0;

   always #5 clk = ~clk;

   turn_scheduler #(.MAX_PLAYERS(4), .TRACK_LEN(24), .REVEAL_CYCLES(RC)) dut (
      .clk(clk), .rst(rst), .start(start), .num_players(num_players),
      .pick_valid(pick_valid), .pick_idx(pick_idx), .pick_ready(pick_ready),
      .cmp_req(cmp_req), .cmp_idx(cmp_idx), .cmp_valid(cmp_valid), .cmp_match(cmp_match),
      .reveal_en(reveal_en), .active(active), .pos_bus(pos_bus), .tails_bus(tails_bus),
      .cfg_err(cfg_err), .winner_valid(winner_valid), .winner(winner)
   );

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic begin_game(input logic [2:0] n);
      num_players = n; start = 1'b1; tick(); start = 1'b0;
   endtask

   task automatic turn(input logic [3:0] idx, input logic m);
      int k;
      pick_idx = idx; pick_valid = 1'b1; tick(); pick_valid = 1'b0;
      cmp_valid = 1'b1; cmp_match = m; tick(); cmp_valid = 1'b0; cmp_match = 1'b0;
      k = 0;
      while (!pick_ready && !winner_valid && k < 100) begin tick(); k++; end
      chk("turn_done", 32'(k < 100), 1);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_pick_ready"}, pick_ready, 0);
      chk({tag, "_cmp_req"}, cmp_req, 0);
      chk({tag, "_cmp_idx"}, cmp_idx, 0);
      chk({tag, "_reveal_en"}, reveal_en, 0);
      chk({tag, "_active"}, active, 0);
      chk({tag, "_pos_bus"}, pos_bus, 0);
      chk({tag, "_tails_bus"}, tails_bus, 0);
      chk({tag, "_cfg_err"}, cfg_err, 0);
      chk({tag, "_winner_valid"}, winner_valid, 0);
      chk({tag, "_winner"}, winner, 0);
   endtask

   initial begin
      int k;
      tick(); tick();
      chk_zero("reset");
      rst = 1'b0;

      // invalid player counts
      begin_game(3'd5);
      chk("cfg5_err", cfg_err, 1);
      chk("cfg5_ready", pick_ready, 0);
      tick();
      chk("cfg5_pulse", cfg_err, 0);
      begin_game(3'd1);
      chk("cfg1_err", cfg_err, 1);
      chk("cfg1_ready", pick_ready, 0);
      tick();
      chk("cfg1_pulse", cfg_err, 0);

      // N=3 miss
      begin_game(3'd3);
      chk("n3_ready", pick_ready, 1);
      chk("n3_pos", pos_bus, 20'h030C0);
      chk("n3_tails", tails_bus, 12'h049);
      chk("n3_active", active, 0);
      pick_idx = 4'd7; pick_valid = 1'b1; tick(); pick_valid = 1'b0;
      chk("n3_cmp_req", cmp_req, 1);
      chk("n3_cmp_idx", cmp_idx, 7);
      chk("n3_ready_off", pick_ready, 0);
      tick();
      chk("n3_cmp_req_pulse", cmp_req, 0);
      chk("n3_reveal_wait", reveal_en, 0);
      cmp_valid = 1'b1; cmp_match = 1'b0; tick(); cmp_valid = 1'b0;
      k = 0;
      while (reveal_en && k < 100) begin k++; tick(); end
      chk("n3_reveal_len", k, RC);
      tick();
      chk("n3_active_next", active, 1);
      chk("n3_ready_back", pick_ready, 1);
      chk("n3_pos_same", pos_bus, 20'h030C0);
      chk("n3_cmp_idx_held", cmp_idx, 7);
      begin_game(3'd2);
      chk("start_ignored_active", active, 1);
      chk("start_ignored_tails", tails_bus, 12'h049);

      // N=2 win by steal
      rst = 1'b1; tick(); rst = 1'b0;
      begin_game(3'd2);
      chk("n2_pos", pos_bus, 20'h000C0);
      chk("n2_tails", tails_bus, 12'h009);
      for (int i = 0; i < 5; i++) turn(4'(i), 1'b1);
      chk("n2_pos5", pos_bus, 20'h000C5);
      chk("n2_active", active, 0);
      chk("n2_no_win", winner_valid, 0);
      turn(4'd5, 1'b1);
      chk("n2_pos6", pos_bus, 20'h000C6);
      chk("n2_tails_steal", tails_bus, 12'h002);
      chk("n2_wv", winner_valid, 1);
      chk("n2_winner", winner, 0);
      chk("n2_done_ready", pick_ready, 0);
      tick(); tick(); tick();
      chk("n2_wv_sticky", winner_valid, 1);

      // N=4 restart from DONE, wrap steal without win
      begin_game(3'd4);
      chk("n4_wv_clear", winner_valid, 0);
      chk("n4_pos", pos_bus, 20'h930C0);
      chk("n4_tails", tails_bus, 12'h249);
      for (int i = 0; i < 3; i++) turn(4'd1, 1'b0);
      chk("n4_active3", active, 3);
      for (int i = 0; i < 5; i++) turn(4'd2, 1'b1);
      chk("n4_pos23", pos_bus, 20'hBB0C0);
      turn(4'd3, 1'b1);
      chk("n4_wrap_pos", pos_bus, 20'h030C0);
      chk("n4_wrap_tails", tails_bus, 12'h448);
      chk("n4_no_win", winner_valid, 0);
      chk("n4_active_kept", active, 3);
      chk("n4_ready", pick_ready, 1);

      // inputs pulsed during REVEAL are ignored
      pick_idx = 4'd9; pick_valid = 1'b1; tick(); pick_valid = 1'b0;
      chk("rv_cmp_req", cmp_req, 1);
      chk("rv_cmp_idx", cmp_idx, 9);
      cmp_valid = 1'b1; cmp_match = 1'b0; tick(); cmp_valid = 1'b0;
      chk("rv_reveal", reveal_en, 1);
      pick_idx = 4'd2; pick_valid = 1'b1; cmp_valid = 1'b1; cmp_match = 1'b1; tick();
      pick_valid = 1'b0; cmp_valid = 1'b0; cmp_match = 1'b0;
      chk("rv_no_req", cmp_req, 0);
      chk("rv_reveal_on", reveal_en, 1);
      k = 0;
      while (!pick_ready && k < 100) begin tick(); k++; end
      chk("rv_back", 32'(k < 100), 1);
      chk("rv_active_wrap", active, 0);
      chk("rv_pos", pos_bus, 20'h030C0);
      chk("rv_cmp_idx_kept", cmp_idx, 9);

      // reset during COMPARE
      pick_idx = 4'd4; pick_valid = 1'b1; tick(); pick_valid = 1'b0;
      chk("rc_cmp_req", cmp_req, 1);
      rst = 1'b1; tick(); rst = 1'b0;
      chk_zero("rc");
      cmp_valid = 1'b1; cmp_match = 1'b1; tick(); cmp_valid = 1'b0; cmp_match = 1'b0;
      tick();
      chk("rc_late_reveal", reveal_en, 0);
      chk("rc_late_req", cmp_req, 0);
      chk("rc_late_ready", pick_ready, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
